// File: rtl/dsp_file_buffer.sv
// Multi-channel word FIFO buffer behind a simple request/response handshake.
// One request at a time runs IDLE -> ACCESS -> RESP; each channel keeps its own pointers and fill count.
module dsp_file_buffer #(
    parameter int NUM_FILES = 4,
    parameter int DEPTH     = 16,
    parameter int dw        = 32
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst,
    input  logic [7:0]              file_num,
    input  logic                    file_write,
    input  logic                    file_read,
    input  logic [dw-1:0]           file_write_data,
    output logic [dw-1:0]           file_read_data,
    output logic                    file_active,
    input  logic                    file_flush,
    input  logic [7:0]              status_sel,
    output logic [$clog2(DEPTH):0]  status_count,
    output logic                    err_empty,
    output logic                    err_full,
    output logic                    err_num,
    output logic                    err_conflict,
    input  logic                    err_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
    localparam logic [8:0]    NF9  = 9'(NUM_FILES);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    state_t          r_state, w_state_nxt;
    logic [FW-1:0]   r_num;
    logic            r_op_wr;
    logic [dw-1:0]   r_wdata;
    logic [dw-1:0]   r_rd_cap;
    logic            r_rd_empty;
    logic [dw-1:0]   r_rd_data;
    logic [dw-1:0]   r_mem    [NUM_FILES][DEPTH];
    logic [AW-1:0]   r_rd_ptr [NUM_FILES];
    logic [AW-1:0]   r_wr_ptr [NUM_FILES];
    logic [CW-1:0]   r_count  [NUM_FILES];
    logic            r_err_empty, r_err_full, r_err_num, r_err_conflict;

    logic w_req, w_num_ok, w_conflict, w_sample, w_accept;
    logic w_set_num, w_set_conflict, w_set_full, w_set_empty;
    logic w_in_access, w_full, w_empty, w_do_write, w_do_read;
    logic [CW-1:0] w_status;

    // Requests are only looked at in IDLE; a same-cycle flush discards them outright.
    assign w_req          = file_read | file_write;
    assign w_num_ok       = {1'b0, file_num} < NF9;
    assign w_conflict     = file_read & file_write;
    assign w_sample       = (r_state == ST_IDLE) & w_req & ~file_flush;
    assign w_accept       = w_sample & w_num_ok & ~w_conflict;
    assign w_set_num      = w_sample & ~w_num_ok;
    assign w_set_conflict = w_sample & w_conflict;

    assign w_in_access = (r_state == ST_ACCESS) & ~file_flush;
    assign w_full      = (r_count[r_num] == FULL);
    assign w_empty     = (r_count[r_num] == '0);
    assign w_set_full  = w_in_access & r_op_wr & w_full;
    assign w_set_empty = w_in_access & ~r_op_wr & w_empty;
    assign w_do_write  = w_in_access & r_op_wr & ~w_full & ~wb_rst;
    assign w_do_read   = w_in_access & ~r_op_wr & ~w_empty;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (file_flush) w_state_nxt = ST_IDLE;
    end

    // Request latch and datapath storage carry no reset.
    always_ff @(posedge wb_clk) begin
        if (w_accept) begin
            r_num   <= file_num[FW-1:0];
            r_op_wr <= file_write;
            r_wdata <= file_write_data;
        end
        if (w_do_read) r_rd_cap <= r_mem[r_num][r_rd_ptr[r_num]];
        if (w_do_write) r_mem[r_num][r_wr_ptr[r_num]] <= r_wdata;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst || file_flush) begin
            for (int i = 0; i < NUM_FILES; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            if (w_do_write) begin
                r_wr_ptr[r_num] <= r_wr_ptr[r_num] + 1'b1;
                r_count[r_num]  <= r_count[r_num] + 1'b1;
            end
            if (w_do_read) begin
                r_rd_ptr[r_num] <= r_rd_ptr[r_num] + 1'b1;
                r_count[r_num]  <= r_count[r_num] - 1'b1;
            end
        end
    end

    // Read result is published at the end of RESP; an empty read publishes zero.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_rd_empty <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_in_access && !r_op_wr) r_rd_empty <= w_empty;
            if (r_state == ST_RESP && !file_flush && !r_op_wr)
                r_rd_data <= r_rd_empty ? '0 : r_rd_cap;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_err_empty    <= 1'b0;
            r_err_full     <= 1'b0;
            r_err_num      <= 1'b0;
            r_err_conflict <= 1'b0;
        end else begin
            r_err_empty    <= w_set_empty    | (r_err_empty    & ~err_clear);
            r_err_full     <= w_set_full     | (r_err_full     & ~err_clear);
            r_err_num      <= w_set_num      | (r_err_num      & ~err_clear);
            r_err_conflict <= w_set_conflict | (r_err_conflict & ~err_clear);
        end
    end

    always_comb begin
        w_status = '0;
        if ({1'b0, status_sel} < NF9) w_status = r_count[status_sel[FW-1:0]];
    end

    assign status_count   = w_status;
    assign file_read_data = r_rd_data;
    assign file_active    = (r_state != ST_IDLE);
    assign err_empty      = r_err_empty;
    assign err_full       = r_err_full;
    assign err_num        = r_err_num;
    assign err_conflict   = r_err_conflict;

endmodule

// File: tb/tb_dsp_file_buffer.sv
// Directed bench for dsp_file_buffer: per-channel queue model plus a read-result scoreboard.
module tb_dsp_file_buffer;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [7:0]  file_num;
    logic        file_write;
    logic        file_read;
    logic [31:0] file_write_data;
    logic [31:0] file_read_data;
    logic        file_active;
    logic        file_flush;
    logic [7:0]  status_sel;
    logic [4:0]  status_count;
    logic        err_empty, err_full, err_num, err_conflict;
    logic        err_clear;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl [4][$];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;

    dsp_file_buffer #(.NUM_FILES(4), .DEPTH(16), .dw(32)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .file_num(file_num), .file_write(file_write), .file_read(file_read),
        .file_write_data(file_write_data), .file_read_data(file_read_data),
        .file_active(file_active), .file_flush(file_flush),
        .status_sel(status_sel), .status_count(status_count),
        .err_empty(err_empty), .err_full(err_full), .err_num(err_num),
        .err_conflict(err_conflict), .err_clear(err_clear)
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_count(input int ch, input int exp, input string tag);
        status_sel = 8'(ch);
        #1;
        check(tag, 32'(status_count), 32'(exp));
    endtask

    // Drives one request so edge T samples it, then scrambles inputs; returns at the negedge inside ACCESS.
    task automatic issue(input logic [7:0] num, input logic wr, input logic rd, input logic [31:0] d);
        @(negedge wb_clk);
        file_num = num; file_write = wr; file_read = rd; file_write_data = d;
        @(negedge wb_clk);
        file_write = 1'b0; file_read = 1'b0;
        file_write_data = ~d; file_num = num ^ 8'h1;
    endtask

    task automatic do_write(input int ch, input logic [31:0] d, input string tag);
        if (mdl[ch].size() < 16) mdl[ch].push_back(d);
        issue(8'(ch), 1'b1, 1'b0, d);
        check({tag, "_act_access"}, 32'(file_active), 32'd1);
        @(negedge wb_clk);
        check({tag, "_act_resp"}, 32'(file_active), 32'd1);
        @(negedge wb_clk);
        check({tag, "_act_idle"}, 32'(file_active), 32'd0);
    endtask

    task automatic do_read(input int ch, input string tag);
        if (mdl[ch].size() > 0) exp_q.push_back(mdl[ch].pop_front());
        else                    exp_q.push_back(32'h0);
        issue(8'(ch), 1'b0, 1'b1, 32'h0);
        check({tag, "_act_access"}, 32'(file_active), 32'd1);
        @(negedge wb_clk);
        check({tag, "_act_resp"}, 32'(file_active), 32'd1);
        @(negedge wb_clk);
        check({tag, "_act_idle"}, 32'(file_active), 32'd0);
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
        else begin
            last_rd = exp_q.pop_front();
            check({tag, "_data"}, file_read_data, last_rd);
        end
    endtask

    task automatic pulse_clear();
        @(negedge wb_clk);
        err_clear = 1'b1;
        @(negedge wb_clk);
        err_clear = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        wb_rst = 1'b1; file_num = 8'h0; file_write = 1'b0; file_read = 1'b0;
        file_write_data = 32'h0; file_flush = 1'b0; status_sel = 8'h0; err_clear = 1'b0;
        repeat (3) @(negedge wb_clk);
        wb_rst = 1'b0;

        // Reset state
        check("rst_active", 32'(file_active), 32'd0);
        check("rst_rdata", file_read_data, 32'h0);
        check("rst_errs", {28'h0, err_empty, err_full, err_num, err_conflict}, 32'h0);
        for (int i = 0; i < 4; i++) check_count(i, 0, "rst_count");
        check_count(5, 0, "rst_count_oob");

        // Two writes then two reads on file 1
        do_write(1, 32'hA5A5_0001, "f1_w0");
        check_count(1, 1, "f1_cnt1");
        do_write(1, 32'hA5A5_0002, "f1_w1");
        check_count(1, 2, "f1_cnt2");
        do_read(1, "f1_r0");
        check_count(1, 1, "f1_cnt_r1");
        do_read(1, "f1_r1");
        check_count(1, 0, "f1_cnt_r0");

        // Fill file 0, overflow write, drain in order
        for (int i = 0; i < 16; i++) begin
            d = $urandom | 32'h1;
            do_write(0, d, "f0_fill");
        end
        check_count(0, 16, "f0_cnt16");
        check("f0_nofull", 32'(err_full), 32'd0);
        do_write(0, 32'hDEAD_BEEF, "f0_ovf");
        check("f0_err_full", 32'(err_full), 32'd1);
        check_count(0, 16, "f0_cnt_ovf");
        for (int i = 0; i < 16; i++) begin
            do_read(0, "f0_drain");
            check("f0_not_dead", 32'(last_rd == 32'hDEAD_BEEF), 32'd0);
        end
        check_count(0, 0, "f0_cnt0");
        check("f0_rdata_nz", 32'(file_read_data != 32'h0), 32'd1);

        // Empty read on file 2 and sticky clear
        pulse_clear();
        check("clr_full", 32'(err_full), 32'd0);
        do_read(2, "f2_empty");
        check("f2_err_empty", 32'(err_empty), 32'd1);
        pulse_clear();
        check("f2_clr_empty", 32'(err_empty), 32'd0);

        // Bad channel number and conflicting strobes are rejected
        do_write(2, 32'h1234_5678, "f2_pre");
        issue(8'd7, 1'b1, 1'b0, 32'h5555_5555);
        check("num_err", 32'(err_num), 32'd1);
        check("num_idle", 32'(file_active), 32'd0);
        issue(8'd0, 1'b1, 1'b1, 32'h6666_6666);
        check("conf_err", 32'(err_conflict), 32'd1);
        check("conf_idle", 32'(file_active), 32'd0);
        @(negedge wb_clk);
        check("rej_idle2", 32'(file_active), 32'd0);
        check_count(0, 0, "rej_cnt0");
        check_count(2, 1, "rej_cnt2");

        // A request raised while busy is ignored
        issue(8'd2, 1'b1, 1'b0, 32'h0BAD_0BAD);
        mdl[2].push_back(32'h0BAD_0BAD);
        file_num = 8'd2; file_write = 1'b1; file_write_data = 32'hFFFF_0000;
        @(negedge wb_clk);
        @(negedge wb_clk);
        file_write = 1'b0;
        check("busy_idle", 32'(file_active), 32'd0);
        check_count(2, 2, "busy_cnt2");
        do_read(2, "f2_r0");
        do_read(2, "f2_r1");

        // Pointer wrap on file 3
        for (int i = 0; i < 20; i++) begin
            d = 32'h3000_0000 + 32'(i);
            do_write(3, d, "f3_w");
            do_read(3, "f3_r");
        end
        check_count(3, 0, "f3_cnt0");

        // Flush during ACCESS aborts the write
        do_write(1, 32'h1111_0001, "fl_w0");
        do_write(1, 32'h1111_0002, "fl_w1");
        do_read(1, "fl_r0");
        issue(8'd1, 1'b1, 1'b0, 32'h1111_0003);
        file_flush = 1'b1;
        @(negedge wb_clk);
        file_flush = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i].delete();
        check("fl_idle", 32'(file_active), 32'd0);
        check("fl_rdata_held", file_read_data, 32'h1111_0001);
        for (int i = 0; i < 4; i++) check_count(i, 0, "fl_cnt");
        do_read(1, "fl_r_empty");

        // Reset during ACCESS overrides flush, clear and a new request
        do_write(0, 32'h2222_0001, "rs_w0");
        do_write(0, 32'h2222_0002, "rs_w1");
        do_read(0, "rs_r0");
        issue(8'd9, 1'b1, 1'b0, 32'h0);
        issue(8'd0, 1'b1, 1'b0, 32'h2222_0003);
        wb_rst = 1'b1; file_flush = 1'b1; err_clear = 1'b1;
        file_write = 1'b1; file_num = 8'd0;
        @(negedge wb_clk);
        wb_rst = 1'b0; file_flush = 1'b0; err_clear = 1'b0; file_write = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i].delete();
        check("rs_active", 32'(file_active), 32'd0);
        check("rs_rdata", file_read_data, 32'h0);
        check("rs_errs", {28'h0, err_empty, err_full, err_num, err_conflict}, 32'h0);
        for (int i = 0; i < 4; i++) check_count(i, 0, "rs_cnt");
        do_write(3, 32'h4444_0001, "post_w");
        do_read(3, "post_r");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_file_buffer.md
DSP_FILE_BUFFER -- requirements
Module: dsp_file_buffer

Interface
REQ-001 Parameter NUM_FILES, default 4: number of independent file channels.
REQ-002 Parameter DEPTH, default 16, power of two: 32-bit words per channel.
REQ-003 Parameter dw, default 32: data width.
REQ-004 wb_clk  input  1  sole clock; all logic rising-edge.
REQ-005 wb_rst  input  1  synchronous, active-high reset.
REQ-006 file_num  input  8  channel select for a request.
REQ-007 file_write  input  1  write request strobe.
REQ-008 file_read  input  1  read request strobe.
REQ-009 file_write_data  input  dw  data to store on write.
REQ-010 file_read_data  output  dw  registered read result.
REQ-011 file_active  output  1  high while a request is being serviced.
REQ-012 file_flush  input  1  empties all channels.
REQ-013 status_sel  input  8  channel whose fill level is reported.
REQ-014 status_count  output  $clog2(DEPTH)+1  fill level of channel status_sel; 0 if status_sel >= NUM_FILES.
REQ-015 err_empty, err_full, err_num, err_conflict  output  1 each  sticky error flags.
REQ-016 err_clear  input  1  clears all sticky error flags.

Function
REQ-017 Each channel is a circular FIFO: rd_ptr, wr_ptr (log2(DEPTH) bits, wrap DEPTH-1 -> 0), count 0..DEPTH.
REQ-018 FSM states IDLE, ACCESS, RESP; file_active = 1 in ACCESS and RESP, 0 in IDLE.
REQ-019 IDLE samples request at cycle T; valid request -> ACCESS at T+1 -> RESP at T+2 -> IDLE at T+3.
REQ-020 Requests arriving while file_active=1 are ignored: no error, no state change.
REQ-021 file_num >= NUM_FILES: request rejected, FSM stays IDLE, err_num set at T+1.
REQ-022 file_read and file_write both high at T: request rejected, FSM stays IDLE, err_conflict set at T+1.
REQ-023 Write, count < DEPTH: mem[wr_ptr] <= data at end of ACCESS; wr_ptr+1, count+1.
REQ-024 Write to full channel (count == DEPTH): data dropped, pointers unchanged, err_full set, FSM still runs the full ACCESS/RESP sequence.
REQ-025 Read, count > 0: mem[rd_ptr] captured in ACCESS; rd_ptr+1, count-1; file_read_data updated at end of RESP, valid from T+3, held until next successful read.
REQ-026 Read from empty channel: file_read_data <= 0 at end of RESP, pointers unchanged, err_empty set.
REQ-027 write_data and file_num are latched at T; later changes do not affect the request in flight.
REQ-028 file_flush in any state: next cycle all pointers and counts = 0 and FSM = IDLE; in-flight request aborted with no pointer update; file_read_data unchanged.
REQ-029 file_flush has priority over a request sampled in the same cycle; that request is discarded.
REQ-030 err_clear clears flags next cycle; an error set in the same cycle wins (flag = 1).
REQ-031 status_count is combinational from the registered counts; it reflects updates the cycle after they occur.
REQ-032 Channels are independent; an operation changes only the selected channel's state.

Reset
REQ-033 On wb_rst high at a clock edge: FSM = IDLE, file_active = 0, file_read_data = 0, all pointers/counts = 0, all err_* = 0.
REQ-034 Reset overrides flush, err_clear and any request in the same cycle; memory contents are not cleared (unreachable after reset).

Verification
REQ-035 Write 0xA5A5_0001 and 0xA5A5_0002 to file 1, then two reads -> file_active high 2 cycles each, reads return 0001 then 0002, status_count(1) goes 2,1,0.
REQ-036 Write 16 words to file 0, 17th write 0xDEAD_BEEF -> err_full = 1, count stays 16, 16 reads return original order, no 0xDEADBEEF.
REQ-037 Read empty file 2 -> file_read_data = 0 from T+3, err_empty = 1; err_clear -> err_empty = 0 next cycle.
REQ-038 file_num = 7 write, then file_read & file_write together -> err_num, err_conflict = 1, file_active never rises, all counts unchanged.
REQ-039 20 write/read pairs on file 3 -> pointer wrap at 15 -> 0, data matches, count returns to 0.
REQ-040 Write pending in ACCESS with file_flush = 1 -> FSM = IDLE next cycle, all counts 0; same test with wb_rst instead -> all outputs at REQ-033 values.
